// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// PC register and IF/ID pipeline register for the 8-bit-address MIPS-subset
// core. The PC drives the instruction memory directly. The word that memory
// returns combinationally is captured into the IF/ID register on the same
// edge. Decode consumes the word over a valid/ready handshake. Execute can
// redirect the PC, which flushes the word currently held.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous reset, active-low
//   enable          1 = fetch may advance, 0 = PC frozen and no new capture
//   imem_addr       instruction-memory address (always the PC register)
//   imem_rdata      combinational read data from instruction memory
//   redirect_valid  branch/jump taken this cycle
//   redirect_target new PC when redirect_valid = 1
//   instr_valid     IF/ID register holds a live instruction
//   instr_ready     decode accepts the instruction this cycle
//   instr           registered instruction word
//   instr_pc        address the instruction was fetched from
//   instr_pc_plus1  instr_pc + 1, wrapping
//   fetch_count     completed handshakes, saturating at all-ones
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned         ADDR_W   = 8,
    parameter int unsigned         INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_plus1,
    output logic [CNT_W-1:0]   fetch_count
);

    // State registers and their next-state values.
    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic               valid_q,    valid_d;
    logic [INSTR_W-1:0] instr_q,    instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [CNT_W-1:0]   count_q,    count_d;

    logic load;
    logic handshake;

    // A new word may be captured when fetch is enabled and the IF/ID slot is
    // either empty or being drained by decode this cycle.
    assign load      = enable & (~valid_q | instr_ready);
    assign handshake = valid_q & instr_ready;

    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        if (redirect_valid) begin
            // Flush: the held word (if any) is on the wrong path. instr and
            // instr_pc keep their old contents; only the valid bit drops.
            pc_d    = redirect_target;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
        end else if (handshake) begin
            // Fetch is frozen but decode took the word, so the slot empties.
            valid_d = 1'b0;
        end
    end

    // The counter follows the handshake alone, so a word consumed in the
    // same cycle as a redirect is still counted.
    always_comb begin
        count_d = count_q;
        if (handshake && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr      = pc_q;
    assign instr_valid    = valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus1 = instr_pc_q + ADDR_W'(1);
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed test of fetch_stage against a small instruction memory. It covers
// reset, streaming, decode stall, redirect (with and without a handshake),
// PC wrap, enable freeze, mid-stream reset and counter saturation. The
// counter is narrowed to 4 bits so that saturation can be reached quickly.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [ADDR_W-1:0]  instr_pc_plus1;
    logic [CNT_W-1:0]   fetch_count;

    logic [INSTR_W-1:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (8'h00),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus1  (instr_pc_plus1),
        .fetch_count     (fetch_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the whole visible state at once.
    task automatic check_all(input string tag, input logic v, input logic [31:0] w,
                             input logic [7:0] ipc, input logic [7:0] addr,
                             input logic [3:0] cnt);
        check_eq({tag, ".valid"}, 32'(instr_valid), 32'(v));
        check_eq({tag, ".instr"}, instr, w);
        check_eq({tag, ".instr_pc"}, 32'(instr_pc), 32'(ipc));
        check_eq({tag, ".pc_plus1"}, 32'(instr_pc_plus1), 32'(8'(ipc + 8'd1)));
        check_eq({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr));
        check_eq({tag, ".count"}, 32'(fetch_count), 32'(cnt));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'h2005_00CA;
        mem[1] = 32'h00A5_2020;
        mem[2] = 32'h8C0B_0004;
        mem[3] = 32'h016B_5820;
        mem[4] = 32'h1000_FFFF;
        for (int i = 5; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);

        rst_n = 1'b0;
        enable = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = '0;

        step();
        check_all("reset", 1'b0, 32'h0, 8'h00, 8'h00, 4'd0);

        // Streaming from reset.
        rst_n = 1'b1;
        step();
        check_all("e1", 1'b1, mem[0], 8'h00, 8'h01, 4'd0);
        step();
        check_all("e2", 1'b1, mem[1], 8'h01, 8'h02, 4'd1);
        step();
        check_all("e3", 1'b1, mem[2], 8'h02, 8'h03, 4'd2);

        // Decode stall for three cycles.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("stall", 1'b1, mem[2], 8'h02, 8'h03, 4'd2);
        end
        instr_ready = 1'b1;
        step();
        check_all("unstall", 1'b1, mem[3], 8'h03, 8'h04, 4'd3);

        // Redirect to 1 while decode consumes the word at 3.
        redirect_valid = 1'b1;
        redirect_target = 8'h01;
        step();
        check_all("redir", 1'b0, mem[3], 8'h03, 8'h01, 4'd4);
        redirect_valid = 1'b0;
        step();
        check_all("redir_tgt", 1'b1, mem[1], 8'h01, 8'h02, 4'd4);

        // Redirect while stalled: no handshake, no count.
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 8'h04;
        step();
        check_all("redir_stall", 1'b0, mem[1], 8'h01, 8'h04, 4'd4);
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        step();
        check_all("redir_stall_tgt", 1'b1, mem[4], 8'h04, 8'h05, 4'd4);

        // PC wrap through 8'hFF.
        redirect_valid = 1'b1;
        redirect_target = 8'hFF;
        step();
        check_all("wrap_redir", 1'b0, mem[4], 8'h04, 8'hFF, 4'd5);
        redirect_valid = 1'b0;
        step();
        check_all("wrap_ff", 1'b1, 32'h0, 8'hFF, 8'h00, 4'd5);
        step();
        check_all("wrap_00", 1'b1, mem[0], 8'h00, 8'h01, 4'd6);

        // Enable low: one handshake drains the slot, then PC stays frozen.
        enable = 1'b0;
        step();
        check_all("dis1", 1'b0, mem[0], 8'h00, 8'h01, 4'd7);
        step();
        check_all("dis2", 1'b0, mem[0], 8'h00, 8'h01, 4'd7);
        enable = 1'b1;
        step();
        check_all("reen", 1'b1, mem[1], 8'h01, 8'h02, 4'd7);

        // Reset mid-stream overrides a concurrent redirect and handshake.
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 8'h10;
        step();
        check_all("rst_mid", 1'b0, 32'h0, 8'h00, 8'h00, 4'd0);
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        step();
        check_all("rst_resume", 1'b1, mem[0], 8'h00, 8'h01, 4'd0);

        // Twenty more handshakes: the 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) step();
        check_all("sat", 1'b1, mem[20], 8'd20, 8'd21, 4'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
